// File: rtl/dff_pipe_if.sv
// dff_pipe_if: data/valid/control bundle for the dff_pipe delay line.
// Parity signals exist only when DFF_PIPE_PARITY_EN is defined.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic             d_valid;
  logic [WIDTH-1:0] d;
  logic             q_valid;
  logic [WIDTH-1:0] q;
  logic [OCC_W-1:0] occupancy;
`ifdef DFF_PIPE_PARITY_EN
  logic             par_inject;
  logic             parity_err;

  modport master (
    output en, flush, d_valid, d, par_inject,
    input  q_valid, q, occupancy, parity_err
  );
  modport slave (
    input  en, flush, d_valid, d, par_inject,
    output q_valid, q, occupancy, parity_err
  );
`else
  modport master (
    output en, flush, d_valid, d,
    input  q_valid, q, occupancy
  );
  modport slave (
    input  en, flush, d_valid, d,
    output q_valid, q, occupancy
  );
`endif
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: valid-tagged multi-stage register pipeline with stall, flush and live occupancy.
// Optional per-stage parity bit is enabled by defining DFF_PIPE_PARITY_EN.
module dff_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic       clk,
  input logic       reset_n,
  dff_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int LAST  = DEPTH - 1;

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_s;

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_r;
  logic [DEPTH-1:0] par_s;

  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`endif

  // Next-state of every stage: flush beats en, and en=0 holds everything.
  always_comb begin
    data_s  = data_r;
    valid_s = valid_r;
    occ_s   = occ_r;
`ifdef DFF_PIPE_PARITY_EN
    par_s   = par_r;
`endif
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_s[i] = RESET_VAL;
      end
      valid_s = {DEPTH{1'b0}};
      occ_s   = {OCC_W{1'b0}};
`ifdef DFF_PIPE_PARITY_EN
      par_s   = {DEPTH{1'b0}};
`endif
    end else if (bus.en) begin
      for (int i = LAST; i > 0; i--) begin
        data_s[i]  = data_r[i-1];
        valid_s[i] = valid_r[i-1];
`ifdef DFF_PIPE_PARITY_EN
        par_s[i]   = par_r[i-1];
`endif
      end
      // Invalid words enter as RESET_VAL so an empty stage never carries stale data.
      data_s[0]  = bus.d_valid ? bus.d : RESET_VAL;
      valid_s[0] = bus.d_valid;
`ifdef DFF_PIPE_PARITY_EN
      par_s[0]   = bus.d_valid ? (calc_parity(bus.d) ^ bus.par_inject) : 1'b0;
`endif
      occ_s = occ_r + OCC_W'(bus.d_valid) - OCC_W'(valid_r[LAST]);
    end else begin
      data_s  = data_r;
      valid_s = valid_r;
      occ_s   = occ_r;
`ifdef DFF_PIPE_PARITY_EN
      par_s   = par_r;
`endif
    end
  end

  // Stage, valid and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
`ifdef DFF_PIPE_PARITY_EN
      par_r   <= {DEPTH{1'b0}};
`endif
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_s[i];
      end
      valid_r <= valid_s;
      occ_r   <= occ_s;
`ifdef DFF_PIPE_PARITY_EN
      par_r   <= par_s;
`endif
    end
  end

  assign bus.q         = data_r[LAST];
  assign bus.q_valid   = valid_r[LAST];
  assign bus.occupancy = occ_r;
`ifdef DFF_PIPE_PARITY_EN
  assign bus.parity_err = valid_r[LAST] & (calc_parity(data_r[LAST]) ^ par_r[LAST]);
`endif

endmodule
